instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4: instruction buffer entries and maximum in-flight requests; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 mem_req_valid  output  1  instruction memory read request valid.
REQ-006 mem_req_ready  input  1  memory accepts request.
REQ-007 mem_req_addr  output  [0:31]  word-aligned fetch address.
REQ-008 mem_rsp_valid  input  1  read data returned, in request order, always accepted.
REQ-009 mem_rsp_data  input  [0:31]  returned instruction word.
REQ-010 redirect_valid  input  1  one-cycle branch/exception redirect pulse.
REQ-011 redirect_addr  input  [0:31]  new fetch address; bits 30:31 ignored, treated as 0.
REQ-012 instruction_valid  output  1  buffered instruction available to instruction_decode.
REQ-013 instruction_ready  input  1  decode accepts instruction.
REQ-014 instruction  output  [0:31]  oldest buffered instruction word.
REQ-015 instruction_pc  output  [0:31]  address of the presented instruction.

Function
REQ-016 Registers: pc, FIFO of {word, address}, count, outstanding counter, drop counter, 2-state FSM FETCH/DRAIN.
REQ-017 Request handshake on mem_req_valid && mem_req_ready; response handshake on mem_rsp_valid; instruction handshake on instruction_valid && instruction_ready.
REQ-018 In FETCH: mem_req_valid = (outstanding + count < FIFO_DEPTH); mem_req_addr = pc.
REQ-019 On request handshake: pc <= pc + 4 (wraps 0xFFFF_FFFC -> 0x0000_0000); outstanding increments.
REQ-020 Once asserted, mem_req_valid and mem_req_addr hold until handshake; the only permitted withdrawal is the cycle after redirect_valid.
REQ-021 Non-dropped response: write {mem_rsp_data, address} into FIFO; outstanding decrements; instruction_valid visible the next cycle (1-cycle latency).
REQ-022 instruction_valid = (count != 0); instruction and instruction_pc come from the FIFO head; a handshake pops one entry per cycle.
REQ-023 Simultaneous push and pop: count unchanged; sustained one instruction per cycle with FIFO_DEPTH >= 2.
REQ-024 Response address tracked by a FIFO-parallel address queue or equivalent; instruction_pc is exact for every word.
REQ-025 redirect_valid (any state):
- FIFO emptied; pc <= {redirect_addr[0:29], 2'b00}.
- drop <= outstanding after this cycle's events, counting a request accepted this same cycle.
- FSM -> DRAIN if that value is nonzero, else FETCH.
REQ-026 In DRAIN: mem_req_valid = 0; each response is discarded and decrements drop and outstanding; drop reaching 0 -> FETCH, next request issued the following cycle.
REQ-027 Redirect in the same cycle as a response: the response is dropped, never written.
REQ-028 Redirect in the same cycle as an instruction handshake: the handshake completes and all remaining entries are flushed.
REQ-029 Redirect during DRAIN: pc reloaded; drop recomputed per REQ-025; no request issued until drop = 0.
REQ-030 The counters never over- or underflow; a response while outstanding = 0 is a protocol error and is ignored.

Reset
REQ-031 While rst = 0, the following hold:
- pc = RESET_PC; count, outstanding and drop = 0; FSM = FETCH.
- mem_req_valid = 0, instruction_valid = 0.
- mem_req_addr = RESET_PC; instruction and instruction_pc = 0.
REQ-032 Assertion mid-operation discards all buffered and in-flight state immediately; mem_req_valid asserts on the first clock edge after release.

Verification
REQ-033 Reset release, mem_req_ready = 1, 1-cycle memory returning addr as data -> requests 0x0, 0x4, 0x8, ...; instruction_ready = 1 gives one instruction per cycle with instruction = instruction_pc.
REQ-034 instruction_ready = 0, memory always ready -> exactly FIFO_DEPTH (4) requests issued, count = 4, then mem_req_valid = 0 until a pop.
REQ-035 mem_req_ready = 0 for 5 cycles -> mem_req_valid = 1 and mem_req_addr stable at 0x0 throughout.
REQ-036 Redirect to 0x0000_1002 with 3 responses outstanding -> FIFO empty next cycle; 3 responses discarded; next request addr 0x0000_1000; first instruction_pc = 0x0000_1000.
REQ-037 RESET_PC = 0xFFFF_FFF8 -> request sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-038 rst pulsed low with 2 in flight and 2 buffered -> outputs at reset values asynchronously; after release, fetch restarts at RESET_PC and no stale word is presented.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues word-aligned reads, buffers returned words
// with their addresses, and discards in-flight reads after a redirect.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [0:31] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [0:31] mem_rsp_data,
    input  logic        redirect_valid,
    input  logic [0:31] redirect_addr,
    output logic        instruction_valid,
    input  logic        instruction_ready,
    output logic [0:31] instruction,
    output logic [0:31] instruction_pc
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;

    logic [31:0]   word_mem [FIFO_DEPTH];
    logic [31:0]   addr_mem [FIFO_DEPTH];

    logic          req_fire;
    logic          rsp_ok;
    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;
    logic [31:0]   rsp_pc;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^redirect_addr[30:31];

    // Buffered plus in-flight words bound the number of new requests.
    assign occupancy = {1'b0, out_q} + {1'b0, count_q};

    assign mem_req_valid = rst && (state_q == FETCH)
                           && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign mem_req_addr  = pc_q;

    assign req_fire = mem_req_valid && mem_req_ready;
    assign rsp_ok   = mem_rsp_valid && (out_q != '0);
    assign push     = rsp_ok && (state_q == FETCH) && !redirect_valid;
    assign pop      = instruction_valid && instruction_ready;

    // In FETCH every outstanding read belongs to one sequential run
    // ending just below pc, so the oldest one sits out_q words back.
    assign rsp_pc = pc_q - (32'(out_q) << 2);

    assign instruction_valid = rst && (count_q != '0);
    assign instruction       = instruction_valid ? word_mem[rptr_q] : '0;
    assign instruction_pc    = instruction_valid ? addr_mem[rptr_q] : '0;

    // Next-state for pc, counters, FIFO pointers and the FETCH/DRAIN FSM.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        out_d   = out_q + CW'(req_fire) - CW'(rsp_ok);
        count_d = count_q + CW'(push) - CW'(pop);

        if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end

        unique case (state_q)
            FETCH: begin
                state_d = FETCH;
            end
            DRAIN: begin
                if (rsp_ok && (drop_q != '0)) begin
                    drop_d = drop_q - CW'(1);
                end
                if (drop_d == '0) begin
                    state_d = FETCH;
                end
            end
        endcase

        if (redirect_valid) begin
            pc_d    = {redirect_addr[0:29], 2'b00};
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            drop_d  = out_d;
            state_d = (out_d != '0) ? DRAIN : FETCH;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            count_q <= '0;
            out_q   <= '0;
            drop_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // Buffer storage; contents are masked at the outputs when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wptr_q] <= mem_rsp_data;
            addr_mem[wptr_q] <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: random memory, decode and
// redirect traffic against a queue-based model of the fetch stream.
module tb_instruction_fetch;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [0:31] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [0:31] mem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [0:31] redirect_addr = '0;
    logic        instruction_valid;
    logic        instruction_ready = 1'b0;
    logic [0:31] instruction;
    logic [0:31] instruction_pc;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_addr      (mem_req_addr),
        .mem_rsp_valid     (mem_rsp_valid),
        .mem_rsp_data      (mem_rsp_data),
        .redirect_valid    (redirect_valid),
        .redirect_addr     (redirect_addr),
        .instruction_valid (instruction_valid),
        .instruction_ready (instruction_ready),
        .instruction       (instruction),
        .instruction_pc    (instruction_pc)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        bit          old;
    } ent_t;

    ent_t        inflight[$];
    ent_t        expq[$];
    logic [31:0] model_pc = RESET_PC;
    bit          rst_lvl = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_deliv = 0;

    bit          prev_valid = 1'b0;
    bit          prev_ready = 1'b0;
    bit          prev_redir = 1'b0;
    logic [31:0] prev_addr = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic monitor_cycle();
        int   n_old;
        bit   exp_req;
        ent_t e;
        n_old = 0;
        foreach (inflight[i]) if (inflight[i].old) n_old++;
        exp_req = rst && (n_old == 0)
                  && (inflight.size() + expq.size() < DEPTH);
        check("req_valid", 32'(mem_req_valid), 32'(exp_req));
        check("inst_valid", 32'(instruction_valid),
              32'(rst && expq.size() != 0));
        if (!rst) begin
            check("rst_addr", mem_req_addr, RESET_PC);
            check("rst_inst", instruction, 32'h0);
            check("rst_pc", instruction_pc, 32'h0);
        end
        if (rst && prev_valid && !prev_ready && !prev_redir) begin
            check("req_hold_valid", 32'(mem_req_valid), 32'h1);
            check("req_hold_addr", mem_req_addr, prev_addr);
        end
        if (rst && instruction_valid && instruction_ready) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_empty: got word %h expected none",
                         instruction);
            end else begin
                e = expq.pop_front();
                check("inst_word", instruction, e.data);
                check("inst_pc", instruction_pc, e.pc);
                n_deliv++;
            end
        end
        prev_valid = rst && mem_req_valid;
        prev_ready = mem_req_ready;
        prev_redir = redirect_valid;
        prev_addr  = mem_req_addr;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            monitor_cycle();
        end
    end

    task automatic model_update();
        ent_t        e;
        logic [31:0] ra;
        if (mem_req_valid && mem_req_ready) begin
            check("req_addr", mem_req_addr, model_pc);
            e.data = $urandom;
            e.pc   = model_pc;
            e.old  = 1'b0;
            inflight.push_back(e);
            model_pc = model_pc + 32'd4;
        end
        if (mem_rsp_valid) begin
            e = inflight.pop_front();
            if (!e.old && !redirect_valid) expq.push_back(e);
        end
        if (redirect_valid) begin
            expq.delete();
            foreach (inflight[i]) inflight[i].old = 1'b1;
            ra = redirect_addr;
            model_pc = ra & 32'hFFFF_FFFC;
        end
    endtask

    task automatic step(input int p_rdy, input int p_rsp, input int p_ird,
                        input int p_redir, input bit force_redir = 1'b0,
                        input logic [31:0] faddr = 32'h0);
        @(negedge clk);
        rst = rst_lvl;
        mem_req_ready     = ($urandom_range(99) < p_rdy);
        instruction_ready = ($urandom_range(99) < p_ird);
        if (inflight.size() > 0 && $urandom_range(99) < p_rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = inflight[0].data;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom;
        end
        redirect_valid = force_redir || ($urandom_range(99) < p_redir);
        redirect_addr  = force_redir ? faddr : $urandom;
        #2;
        if (rst) model_update();
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #3;
        rst = 1'b0;
        rst_lvl = 1'b0;
        inflight.delete();
        expq.delete();
        model_pc = RESET_PC;
        mem_rsp_valid  = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("async_req_valid", 32'(mem_req_valid), 32'h0);
        check("async_inst_valid", 32'(instruction_valid), 32'h0);
        check("async_addr", mem_req_addr, RESET_PC);
        check("async_inst", instruction, 32'h0);
    endtask

    initial begin
        int base;
        repeat (3) step(100, 100, 100, 0);
        rst_lvl = 1'b1;

        base = n_deliv;
        repeat (30) step(100, 100, 100, 0);
        check("stream_rate", 32'(n_deliv - base >= 25), 32'h1);

        repeat (10) step(100, 100, 0, 0);
        repeat (8) step(0, 100, 100, 0);
        repeat (6) step(0, 100, 0, 0);

        repeat (10) step(100, 100, 100, 0);
        repeat (3) step(100, 0, 100, 0);
        step(100, 0, 100, 0, 1'b1, 32'h0000_1002);
        repeat (12) step(100, 100, 100, 0);

        repeat (3000) step(70, 60, 70, 3);

        repeat (2) step(100, 0, 0, 0);
        repeat (2) step(100, 100, 0, 0);
        mid_reset();
        repeat (2) step(100, 100, 100, 0);
        rst_lvl = 1'b1;
        repeat (20) step(100, 100, 100, 0);

        repeat (1500) step($urandom_range(100), $urandom_range(100),
                           $urandom_range(100), 5);
        repeat (20) step(100, 100, 100, 0);

        check("delivered", 32'(n_deliv > 500), 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
